// File: rtl/pkt_wrr_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | pkt_wrr_arbiter : packet-atomic weighted round-robin merge of N FWFT     |
// | AXIS FIFOs onto one AXIS output. Optional macro ARB_PRIO0_EN gives port 0|
// | strict priority at packet boundaries.                                    |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module pkt_wrr_arbiter #(
  parameter int N_PORTS = 6,
  parameter int DW      = 256,
  parameter int UW      = 128,
  parameter int WW      = 4
) (
  input  logic                    axis_aclk,
  input  logic                    axis_resetn,
  input  logic [N_PORTS*DW-1:0]   s_tdata,
  input  logic [N_PORTS*DW/8-1:0] s_tkeep,
  input  logic [N_PORTS*UW-1:0]   s_tuser,
  input  logic [N_PORTS-1:0]      s_tlast,
  input  logic [N_PORTS-1:0]      s_tvalid,
  output logic [N_PORTS-1:0]      s_tready,
  input  logic [N_PORTS*WW-1:0]   i_weight,
  output logic [DW-1:0]           m_tdata,
  output logic [DW/8-1:0]         m_tkeep,
  output logic [UW-1:0]           m_tuser,
  output logic                    m_tlast,
  output logic                    m_tvalid,
  input  logic                    m_tready,
  output logic [2:0]              o_grant,
  output logic                    o_busy
);

  typedef enum logic [0:0] {S_IDLE = 1'b0, S_XFER = 1'b1} state_t;

  localparam logic [WW:0] C_ONE = {{WW{1'b0}}, 1'b1};

  state_t        r_state, w_state_nxt;
  logic [2:0]    r_ptr, r_grant, r_last_grant;
  logic [WW-1:0] r_turn_cnt;

  logic          w_found;
  logic [2:0]    w_winner, w_sel, w_grant_inc;
  logic          w_sel_prio, w_grant_prio;
  logic          w_vld_g, w_last_g, w_eop, w_turn_done;
  logic [WW-1:0] w_weight;
  logic [WW:0]   w_eff_wt, w_cnt_inc;

  // First requester scanning upward from r_ptr with wrap.
  always_comb begin
    logic [3:0] v_idx;
    logic       v_hit;
    w_found  = 1'b0;
    w_winner = r_ptr;
    for (int i = 0; i < N_PORTS; i++) begin
      v_idx = {1'b0, r_ptr} + 4'(i);
      if (v_idx >= 4'(N_PORTS)) v_idx = v_idx - 4'(N_PORTS);
      v_hit = 1'b0;
      for (int q = 0; q < N_PORTS; q++) begin
        if (v_idx == 4'(q)) v_hit = s_tvalid[q];
      end
      if (!w_found && v_hit) begin
        w_found  = 1'b1;
        w_winner = v_idx[2:0];
      end
    end
  end

`ifdef ARB_PRIO0_EN
  assign w_sel_prio   = s_tvalid[0];
  assign w_sel        = s_tvalid[0] ? 3'd0 : w_winner;
  assign w_grant_prio = (r_grant == 3'd0);
`else
  assign w_sel_prio   = 1'b0;
  assign w_sel        = w_winner;
  assign w_grant_prio = 1'b0;
`endif

  always_comb begin
    m_tdata  = '0;
    m_tkeep  = '0;
    m_tuser  = '0;
    w_last_g = 1'b0;
    w_vld_g  = 1'b0;
    w_weight = '0;
    for (int p = 0; p < N_PORTS; p++) begin
      if (r_grant == 3'(p)) begin
        m_tdata  = s_tdata[p*DW +: DW];
        m_tkeep  = s_tkeep[p*(DW/8) +: DW/8];
        m_tuser  = s_tuser[p*UW +: UW];
        w_last_g = s_tlast[p];
        w_vld_g  = s_tvalid[p];
        w_weight = i_weight[p*WW +: WW];
      end
    end
  end

  assign m_tlast     = w_last_g;
  assign o_grant     = r_grant;
  assign w_eop       = (r_state == S_XFER) && w_vld_g && m_tready && w_last_g;
  assign w_eff_wt    = (w_weight == '0) ? C_ONE : {1'b0, w_weight};
  assign w_cnt_inc   = {1'b0, r_turn_cnt} + C_ONE;
  assign w_turn_done = (w_cnt_inc >= w_eff_wt);
  assign w_grant_inc = (r_grant == 3'(N_PORTS-1)) ? 3'd0 : r_grant + 3'd1;

  always_ff @(posedge axis_aclk or negedge axis_resetn) begin
    if (!axis_resetn) r_state <= S_IDLE;
    else              r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    o_busy      = 1'b0;
    m_tvalid    = 1'b0;
    s_tready    = '0;
    case (r_state)
      S_IDLE: begin
        if (w_found) w_state_nxt = S_XFER;
      end
      S_XFER: begin
        o_busy   = 1'b1;
        m_tvalid = w_vld_g;
        for (int p = 0; p < N_PORTS; p++) begin
          if (r_grant == 3'(p)) s_tready[p] = m_tready;
        end
        if (w_eop) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Priority-port packets leave the WRR bookkeeping untouched.
  always_ff @(posedge axis_aclk or negedge axis_resetn) begin
    if (!axis_resetn) begin
      r_ptr        <= 3'd0;
      r_grant      <= 3'd0;
      r_last_grant <= 3'd0;
      r_turn_cnt   <= '0;
    end else begin
      if ((r_state == S_IDLE) && w_found) begin
        r_grant <= w_sel;
        if (!w_sel_prio && (w_sel != r_last_grant)) r_turn_cnt <= '0;
      end
      if (w_eop && !w_grant_prio) begin
        r_last_grant <= r_grant;
        if (w_turn_done) begin
          r_turn_cnt <= '0;
          r_ptr      <= w_grant_inc;
        end else begin
          r_turn_cnt <= w_cnt_inc[WW-1:0];
          r_ptr      <= r_grant;
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_pkt_wrr_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_pkt_wrr_arbiter : directed self-checking bench for pkt_wrr_arbiter.   |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_pkt_wrr_arbiter;
  localparam int N  = 6;
  localparam int DW = 256;
  localparam int UW = 128;
  localparam int WW = 4;

  logic              clk = 1'b0;
  logic              axis_resetn = 1'b0;
  logic [N*DW-1:0]   s_tdata = '0;
  logic [N*DW/8-1:0] s_tkeep = '1;
  logic [N*UW-1:0]   s_tuser = '0;
  logic [N-1:0]      s_tlast = '0;
  logic [N-1:0]      s_tvalid = '0;
  logic [N-1:0]      s_tready;
  logic [N*WW-1:0]   i_weight = '0;
  logic [DW-1:0]     m_tdata;
  logic [DW/8-1:0]   m_tkeep;
  logic [UW-1:0]     m_tuser;
  logic              m_tlast, m_tvalid;
  logic              m_tready = 1'b1;
  logic [2:0]        o_grant;
  logic              o_busy;

  pkt_wrr_arbiter #(.N_PORTS(N), .DW(DW), .UW(UW), .WW(WW)) dut (
    .axis_aclk(clk), .axis_resetn(axis_resetn),
    .s_tdata(s_tdata), .s_tkeep(s_tkeep), .s_tuser(s_tuser),
    .s_tlast(s_tlast), .s_tvalid(s_tvalid), .s_tready(s_tready),
    .i_weight(i_weight),
    .m_tdata(m_tdata), .m_tkeep(m_tkeep), .m_tuser(m_tuser),
    .m_tlast(m_tlast), .m_tvalid(m_tvalid), .m_tready(m_tready),
    .o_grant(o_grant), .o_busy(o_busy)
  );

  always #5 clk = ~clk;

  // Per-port FWFT FIFO model; word = {last, 0, port, pkt, word}.
  logic [16:0] fifo [N][64];
  int          hd [N], tl [N], nk [N], ek [N], ew [N];
  int          plen [N][16];
  int          glog [64];
  int          gn;
  bit          in_pkt, hold_chk, pat_en;
  logic [15:0] held;
  logic [N-1:0] rdy_s, vld_s;
  logic [3:0]  pat = 4'b1001;
  int          pi;
  int          n_cmp = 0, n_err = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic drive();
    logic [15:0] d;
    logic        l;
    for (int p = 0; p < N; p++) begin
      s_tvalid[p] = (hd[p] < tl[p]);
      if (hd[p] < tl[p]) {l, d} = fifo[p][hd[p]];
      else               {l, d} = 17'h0;
      s_tlast[p]            = l;
      s_tdata[p*DW +: DW]   = DW'(d);
      s_tuser[p*UW +: UW]   = UW'(d ^ 16'h5A5A);
    end
    if (pat_en) begin
      m_tready = pat[pi % 4];
      pi++;
    end else begin
      m_tready = 1'b1;
    end
  endtask

  task automatic monitor();
    int          g;
    bit          ok, el;
    logic [15:0] d;
    rdy_s = s_tready;
    vld_s = s_tvalid;
    if (hold_chk) begin
      chk("stall_hold", {m_tvalid, m_tdata[15:0]}, {1'b1, held});
      hold_chk = 0;
    end
    if (m_tvalid && !m_tready) begin
      held     = m_tdata[15:0];
      hold_chk = 1;
    end
    if (m_tvalid && m_tready) begin
      g  = int'(o_grant);
      ok = (g < N) ? (ek[g] < 16) : 1'b0;
      chk("word_range", 64'(ok), 64'(1));
      if (ok) begin
        d  = {1'b0, 3'(g), 6'(ek[g]), 6'(ew[g])};
        el = (ew[g] == plen[g][ek[g]] - 1);
        chk("word", {m_tlast, m_tuser[15:0], m_tdata[15:0], 8'(s_tready)},
                    {el, d ^ 16'h5A5A, d, 8'(1 << g)});
        if (!in_pkt) begin
          if (gn < 64) glog[gn] = g;
          gn++;
        end
        in_pkt = !el;
        if (el) begin ek[g]++; ew[g] = 0; end
        else    ew[g]++;
      end
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
    for (int p = 0; p < N; p++) if (rdy_s[p] && vld_s[p]) hd[p]++;
    drive();
    #1;
    monitor();
  endtask

  task automatic add_pkt(input int p, input int len);
    int k;
    k = nk[p];
    plen[p][k] = len;
    for (int w = 0; w < len; w++) begin
      fifo[p][tl[p]] = {(w == len - 1), 1'b0, 3'(p), 6'(k), 6'(w)};
      tl[p]++;
    end
    nk[p]++;
  endtask

  task automatic reset_dut();
    axis_resetn = 1'b0;
    for (int p = 0; p < N; p++) begin
      hd[p] = 0; tl[p] = 0; nk[p] = 0; ek[p] = 0; ew[p] = 0;
    end
    pat_en = 0;
    drive();
    rdy_s = '0; vld_s = '0;
    gn = 0; in_pkt = 0; hold_chk = 0;
    repeat (2) @(posedge clk);
    #1 axis_resetn = 1'b1;
    #1;
  endtask

  function automatic bit pending();
    bit r;
    r = 0;
    for (int p = 0; p < N; p++) if (hd[p] < tl[p]) r = 1;
    return r;
  endfunction

  task automatic run_until_done(input string tag, input int max);
    int c;
    c = 0;
    while ((pending() || o_busy) && c < max) begin
      cyc();
      c++;
    end
    chk({tag, "_done"}, 64'(c < max), 64'(1));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int t3 [14] = '{0, 0, 1, 2, 3, 4, 5, 0, 0, 1, 2, 3, 4, 5};
    int t6 [5];
`ifdef ARB_PRIO0_EN
    t6 = '{0, 0, 0, 4, 4};
`else
    t6 = '{0, 4, 0, 4, 0};
`endif

    // Reset values and a lone 3-word packet on port 2.
    reset_dut();
    chk("rst_tvalid", 64'(m_tvalid), 64'(0));
    chk("rst_tready", 64'(s_tready), 64'(0));
    chk("rst_busy", 64'(o_busy), 64'(0));
    chk("rst_grant", 64'(o_grant), 64'(0));
    i_weight = {N{4'd1}};
    add_pkt(2, 3);
    cyc();
    chk("t1_cycle1_tvalid", 64'(m_tvalid), 64'(0));
    cyc();
    chk("t1_cycle2_tvalid", 64'(m_tvalid), 64'(1));
    chk("t1_grant", 64'(o_grant), 64'(2));
    chk("t1_busy", 64'(o_busy), 64'(1));
    repeat (3) cyc();
    chk("t1_idle_busy", 64'(o_busy), 64'(0));
    chk("t1_pkts", 64'(ek[2]), 64'(1));
    add_pkt(1, 1);
    add_pkt(4, 2);
    run_until_done("t1", 50);
    chk("t1_count", 64'(gn), 64'(3));
    chk("t1_after_ptr3", 64'(glog[1]), 64'(4));
    chk("t1_wrap", 64'(glog[2]), 64'(1));

`ifndef ARB_PRIO0_EN
    // Equal weights, all ports backlogged.
    reset_dut();
    i_weight = {N{4'd1}};
    for (int p = 0; p < N; p++)
      for (int k = 0; k < 4; k++) add_pkt(p, (p + k) % 3 + 1);
    run_until_done("t2", 400);
    chk("t2_count", 64'(gn), 64'(24));
    for (int i = 0; i < 24; i++) chk("t2_order", 64'(glog[i]), 64'(i % 6));

    // Port 0 weight 2.
    reset_dut();
    i_weight = {4'd1, 4'd1, 4'd1, 4'd1, 4'd1, 4'd2};
    for (int k = 0; k < 4; k++) add_pkt(0, 2);
    for (int p = 1; p < N; p++) begin
      add_pkt(p, 1);
      add_pkt(p, 1);
    end
    run_until_done("t3", 200);
    chk("t3_count", 64'(gn), 64'(14));
    for (int i = 0; i < 14; i++) chk("t3_order", 64'(glog[i]), 64'(t3[i]));
`endif

    // Backpressure 1,0,0,1 over a 4-word packet; weight 0 acts as 1.
    i_weight = '0;
    pat_en = 1;
    pi = 0;
    add_pkt(1, 4);
    run_until_done("t4", 60);
    pat_en = 0;
    chk("t4_pkts", 64'(ek[1]), 64'(nk[1]));
    chk("t4_words_left", 64'(ew[1]), 64'(0));

    // Reset in the middle of a port-3 packet.
    reset_dut();
    add_pkt(3, 2);
    run_until_done("t5a", 50);
    add_pkt(3, 6);
    repeat (4) cyc();
    chk("t5_busy_before", 64'(o_busy), 64'(1));
    #1 axis_resetn = 1'b0;
    #1;
    chk("t5_rst_tvalid", 64'(m_tvalid), 64'(0));
    chk("t5_rst_tready", 64'(s_tready), 64'(0));
    chk("t5_rst_busy", 64'(o_busy), 64'(0));
    chk("t5_rst_grant", 64'(o_grant), 64'(0));
    reset_dut();
    add_pkt(1, 2);
    add_pkt(5, 2);
    run_until_done("t5b", 50);
    chk("t5_count", 64'(gn), 64'(2));
    chk("t5_first", 64'(glog[0]), 64'(1));
    chk("t5_second", 64'(glog[1]), 64'(5));

    // Ports 0 and 4 backlogged.
    reset_dut();
    for (int k = 0; k < 3; k++) add_pkt(0, 2);
    add_pkt(4, 2);
    add_pkt(4, 2);
    run_until_done("t6", 100);
    chk("t6_count", 64'(gn), 64'(5));
    for (int i = 0; i < 5; i++) chk("t6_order", 64'(glog[i]), 64'(t6[i]));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
`default_nettype wire
